// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pkg
// Description : Shared state encoding and defaults for the step pulse
//               generator and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

    // Default number of cycles dir_out is held before the first STEP rise.
    localparam int unsigned C_DIR_SETUP_DEFAULT = 8;

    // State encodings, 3 bits wide.
    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_SETUP = 3'd1;
    localparam logic [2:0] C_ST_HIGH  = 3'd2;
    localparam logic [2:0] C_ST_LOW   = 3'd3;
    localparam logic [2:0] C_ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_SETUP = C_ST_SETUP,
        ST_HIGH  = C_ST_HIGH,
        ST_LOW   = C_ST_LOW,
        ST_DONE  = C_ST_DONE
    } state_t;

endpackage : stepper_pkg
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Loadable down-counter. Loading value V gives V+1 cycles,
//               with expired high on the last of them (count == 0).
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    output logic                  expired
);

    logic [DATA_WIDTH-1:0] r_count;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule : cycle_timer
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_gen
// Description : Generates a timed STEP/DIR pulse train for a stepper driver
//               with start/abort/done handshake and a steps_done count.
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_gen
    import stepper_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIR_SETUP  = C_DIR_SETUP_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  direction,
    input  logic [DATA_WIDTH-1:0] step_count,
    input  logic [DATA_WIDTH-1:0] half_period,
    output logic                  step_out,
    output logic                  dir_out,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] steps_done
);

    localparam logic [DATA_WIDTH-1:0] C_SETUP_M1 = DATA_WIDTH'(DIR_SETUP - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_half;
    logic [DATA_WIDTH-1:0] r_steps;
    logic                  r_abort_pending;
    logic                  r_step_out;
    logic                  r_dir;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_value;
    logic                  w_steps_inc;
    logic                  w_set_pending;
    logic                  w_expired;
    logic [DATA_WIDTH-1:0] w_h_m1;

    // A zero half-period is treated as one cycle per phase.
    assign w_h_m1   = (r_half == '0) ? '0 : (r_half - 1'b1);
    assign w_accept = (r_state == ST_IDLE) && start && !abort;

    cycle_timer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load       (w_load),
        .load_value (w_load_value),
        .expired    (w_expired)
    );

    // Next-state decode and phase timer reload.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_value  = w_h_m1;
        w_steps_inc   = 1'b0;
        w_set_pending = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_load_value = C_SETUP_M1;
                    w_state_nxt  = (step_count == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // The high phase always runs to completion; an abort only
                // redirects the exit to DONE.
                if (w_expired) begin
                    w_steps_inc = 1'b1;
                    if (abort || r_abort_pending) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_LOW;
                    end
                end else if (abort) begin
                    w_set_pending = 1'b1;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    if (r_steps == r_count) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_HIGH;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched move parameters, step counter and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state         <= ST_IDLE;
            r_count         <= '0;
            r_half          <= '0;
            r_steps         <= '0;
            r_abort_pending <= 1'b0;
            r_step_out      <= 1'b0;
            r_dir           <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_out <= (w_state_nxt == ST_HIGH);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_dir   <= direction;
                r_count <= step_count;
                r_half  <= half_period;
                r_steps <= '0;
            end else if (w_steps_inc) begin
                r_steps <= r_steps + 1'b1;
            end
            if (w_state_nxt == ST_IDLE) begin
                r_abort_pending <= 1'b0;
            end else if (w_set_pending) begin
                r_abort_pending <= 1'b1;
            end
        end
    end

    assign step_out   = r_step_out;
    assign dir_out    = r_dir;
    assign busy       = r_busy;
    assign done       = r_done;
    assign steps_done = r_steps;

endmodule : step_pulse_gen
`default_nettype wire
